// File: rtl/effect_pkg.sv
// Shared types and helpers for the feedback echo effect: FSM state encoding,
// DATA_W saturation and the level-to-delay mapping.
package effect_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_READ  = 2'd2,
      ST_WRITE = 2'd3
   } echo_state_e;

   localparam int unsigned LEVEL_STEPS = 32'd8;

   function automatic logic signed [31:0] sat_w(input logic signed [31:0] v, input int unsigned w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (v > hi) begin
         sat_w = hi;
      end else if (v < lo) begin
         sat_w = lo;
      end else begin
         sat_w = v;
      end
   endfunction

   // D = min((level+1)*(depth/8), depth-1)
   function automatic logic [31:0] level_to_delay(input logic [2:0] level, input int unsigned depth);
      logic [31:0] d;
      d = (32'(level) + 32'd1) * (depth / LEVEL_STEPS);
      if (d > depth - 32'd1) begin
         level_to_delay = depth - 32'd1;
      end else begin
         level_to_delay = d;
      end
   endfunction

endpackage

// File: rtl/echo_mixer.sv
// Combinational wet/dry mixer and feedback term for the echo effect.
// Both results are computed at DATA_W+4 bits and saturated back to DATA_W.
module echo_mixer
   import effect_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [DATA_W-1:0] y,
   input  logic        [1:0]        m,
   input  logic        [2:0]        f,
   input  logic                     enable,
   output logic signed [DATA_W-1:0] out_data,
   output logic signed [DATA_W-1:0] wr_data
);

   localparam int WW = DATA_W + 4;
   localparam logic signed [WW-1:0] FOUR_S = WW'(4'sd4);

   logic signed [WW-1:0] x_s;
   logic signed [WW-1:0] y_s;
   logic signed [WW-1:0] m_s;
   logic signed [WW-1:0] f_s;
   logic signed [WW-1:0] mix_s;
   logic signed [WW-1:0] fb_s;

   // mix = (x*(4-m) + y*m) >>> 2, feedback write = x + (y*f) >>> 3
   always_comb begin
      x_s   = WW'(x);
      y_s   = WW'(y);
      m_s   = WW'($signed({1'b0, m}));
      f_s   = WW'($signed({1'b0, f}));
      mix_s = (x_s * (FOUR_S - m_s) + y_s * m_s) >>> 2'd2;
      fb_s  = x_s + ((y_s * f_s) >>> 2'd3);
      if (enable) begin
         out_data = DATA_W'(sat_w(32'(mix_s), DATA_W));
         wr_data  = DATA_W'(sat_w(32'(fb_s), DATA_W));
      end else begin
         out_data = x;
         wr_data  = x;
      end
   end

endmodule

// File: rtl/effect_echo_fb.sv
// Feedback echo effect: keeps a circular sample history in external SRAM and
// returns a wet/dry mix of the current and delayed sample.
module effect_echo_fb
   import effect_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 20,
   parameter int DEPTH    = 32000,
   parameter int SRAM_LAT = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   input  logic signed [DATA_W-1:0] i_data,
   input  logic                     i_enable,
   input  logic        [2:0]        i_level,
   input  logic        [1:0]        i_mix,
   input  logic        [2:0]        i_fb,
   input  logic signed [DATA_W-1:0] i_sram_rdata,
   output logic        [ADDR_W-1:0] o_sram_addr,
   output logic                     o_sram_we_n,
   output logic signed [DATA_W-1:0] o_sram_wdata,
   output logic signed [DATA_W-1:0] o_data,
   output logic                     o_valid,
   output logic                     o_busy,
   output logic                     o_overrun
);

   localparam int CNT_W = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
   localparam logic [CNT_W-1:0]  LAT_LAST  = CNT_W'(SRAM_LAT - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

   echo_state_e              state_r;
   logic        [ADDR_W-1:0] wp_r;
   logic        [CNT_W-1:0]  lat_cnt_r;
   logic signed [DATA_W-1:0] x_r;
   logic signed [DATA_W-1:0] y_r;
   logic        [1:0]        m_r;
   logic        [2:0]        f_r;
   logic                     en_r;
   logic                     busy_r;
   logic                     overrun_r;
   logic signed [DATA_W-1:0] data_r;
   logic                     valid_r;
   logic        [ADDR_W-1:0] addr_r;
   logic                     we_n_r;
   logic signed [DATA_W-1:0] wdata_r;

   logic        [31:0]       d_s;
   logic        [ADDR_W-1:0] rp_s;
   logic        [ADDR_W-1:0] wp_next_s;
   logic signed [DATA_W-1:0] y_mix_s;
   logic signed [DATA_W-1:0] out_s;
   logic signed [DATA_W-1:0] w_s;

   // Read pointer from the delay requested with the sample being captured.
   // During READ the mixer sees live SRAM data so the write value is ready
   // at the same edge that latches y.
   always_comb begin
      d_s = level_to_delay(i_level, DEPTH);
      if (32'(wp_r) >= d_s) begin
         rp_s = ADDR_W'(32'(wp_r) - d_s);
      end else begin
         rp_s = ADDR_W'(32'(wp_r) + 32'(DEPTH) - d_s);
      end
      if (wp_r == ADDR_LAST) begin
         wp_next_s = '0;
      end else begin
         wp_next_s = wp_r + ADDR_W'(1'b1);
      end
      if (state_r == ST_READ) begin
         y_mix_s = i_sram_rdata;
      end else begin
         y_mix_s = y_r;
      end
   end

   echo_mixer #(.DATA_W(DATA_W)) u_mixer (
      .x        (x_r),
      .y        (y_mix_s),
      .m        (m_r),
      .f        (f_r),
      .enable   (en_r),
      .out_data (out_s),
      .wr_data  (w_s)
   );

   // Main FSM: buffer clear, sample capture, delayed read, write-back and output.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r   <= ST_CLEAR;
         busy_r    <= 1'b1;
         addr_r    <= '0;
         we_n_r    <= 1'b0;
         wdata_r   <= '0;
         wp_r      <= '0;
         lat_cnt_r <= '0;
         x_r       <= '0;
         y_r       <= '0;
         m_r       <= 2'd0;
         f_r       <= 3'd0;
         en_r      <= 1'b0;
         data_r    <= '0;
         valid_r   <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         if (i_valid && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
         end
         case (state_r)
            ST_CLEAR: begin
               if (addr_r == ADDR_LAST) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  addr_r  <= '0;
                  we_n_r  <= 1'b1;
               end else begin
                  addr_r  <= addr_r + ADDR_W'(1'b1);
               end
            end
            ST_IDLE: begin
               if (i_valid) begin
                  x_r       <= i_data;
                  m_r       <= i_mix;
                  f_r       <= i_fb;
                  en_r      <= i_enable;
                  lat_cnt_r <= '0;
                  addr_r    <= rp_s;
                  we_n_r    <= 1'b1;
                  busy_r    <= 1'b1;
                  state_r   <= ST_READ;
               end
            end
            ST_READ: begin
               if (lat_cnt_r == LAT_LAST) begin
                  y_r     <= i_sram_rdata;
                  addr_r  <= wp_r;
                  we_n_r  <= 1'b0;
                  wdata_r <= w_s;
                  state_r <= ST_WRITE;
               end else begin
                  lat_cnt_r <= lat_cnt_r + CNT_W'(1'b1);
               end
            end
            ST_WRITE: begin
               data_r  <= out_s;
               valid_r <= 1'b1;
               wp_r    <= wp_next_s;
               addr_r  <= '0;
               we_n_r  <= 1'b1;
               wdata_r <= '0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_CLEAR;
               busy_r  <= 1'b1;
               addr_r  <= '0;
               we_n_r  <= 1'b0;
               wdata_r <= '0;
            end
         endcase
      end
   end

   assign o_sram_addr  = addr_r;
   assign o_sram_we_n  = we_n_r;
   assign o_sram_wdata = wdata_r;
   assign o_data       = data_r;
   assign o_valid      = valid_r;
   assign o_busy       = busy_r;
   assign o_overrun    = overrun_r;

endmodule

// File: tb/tb_effect_echo_fb.sv
// Scoreboard bench for effect_echo_fb: a queue-based reference echo model predicts
// every output sample and every SRAM write, independent monitors compare them.
module tb_effect_echo_fb;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 8;
   localparam int DEPTH    = 32;
   localparam int SRAM_LAT = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     in_valid;
   logic signed [DATA_W-1:0] in_data;
   logic                     enable;
   logic        [2:0]        level;
   logic        [1:0]        mix;
   logic        [2:0]        fb;
   logic signed [DATA_W-1:0] sram_rdata;
   logic        [ADDR_W-1:0] sram_addr;
   logic                     sram_we_n;
   logic signed [DATA_W-1:0] sram_wdata;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_valid;
   logic                     busy;
   logic                     overrun;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit clearing = 1'b1;

   typedef struct {int data; int cyc;} exp_t;
   typedef struct {int addr; int data;} wr_t;
   exp_t exp_q[$];
   wr_t  wr_q[$];
   int   ref_buf[DEPTH];
   int   ref_wp = 0;

   logic signed [DATA_W-1:0] mem [DEPTH];
   logic signed [DATA_W-1:0] rd_r = '0;

   always #5 clk = ~clk;

   effect_echo_fb #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SRAM_LAT(SRAM_LAT)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_valid      (in_valid),
      .i_data       (in_data),
      .i_enable     (enable),
      .i_level      (level),
      .i_mix        (mix),
      .i_fb         (fb),
      .i_sram_rdata (sram_rdata),
      .o_sram_addr  (sram_addr),
      .o_sram_we_n  (sram_we_n),
      .o_sram_wdata (sram_wdata),
      .o_data       (out_data),
      .o_valid      (out_valid),
      .o_busy       (busy),
      .o_overrun    (overrun)
   );

   // SRAM model: read data valid on the cycle after the address, read-before-write
   always @(posedge clk) begin
      if (int'(sram_addr) < DEPTH) begin
         rd_r <= mem[sram_addr];
         if (!sram_we_n) mem[sram_addr] <= sram_wdata;
      end
   end
   assign sram_rdata = rd_r;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic int clamp(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // output and SRAM-write monitors
   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", int'(out_data), 99999);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", int'(out_data), e.data);
            check("out_latency_cycle", cyc, e.cyc);
         end
      end
      if (!sram_we_n && !clearing) begin
         if (wr_q.size() == 0) begin
            check("unexpected_write", int'(sram_addr), 99999);
         end else begin
            wr_t w;
            w = wr_q.pop_front();
            check("wr_addr", int'(sram_addr), w.addr);
            check("wr_data", int'(sram_wdata), w.data);
         end
      end
   end

   // issue one sample at a negedge; returns gap cycles later
   task automatic send(input int x, input bit en, input int lvl, input int m, input int f, input int gap);
      int d, rp, y, o, w;
      d = (lvl + 1) * (DEPTH / 8);
      if (d > DEPTH - 1) d = DEPTH - 1;
      rp = (ref_wp - d + DEPTH) % DEPTH;
      y  = ref_buf[rp];
      if (en) begin
         o = clamp((x * (4 - m) + y * m) >>> 2);
         w = clamp(x + ((y * f) >>> 3));
      end else begin
         o = x;
         w = x;
      end
      exp_q.push_back('{o, cyc + SRAM_LAT + 2});
      wr_q.push_back('{ref_wp, w});
      ref_buf[ref_wp] = w;
      ref_wp = (ref_wp + 1) % DEPTH;
      in_valid = 1'b1;
      in_data  = DATA_W'(x);
      enable   = en;
      level    = 3'(lvl);
      mix      = 2'(m);
      fb       = 3'(f);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = DATA_W'($urandom);
      enable   = 1'($urandom);
      level    = 3'($urandom);
      mix      = 2'($urandom);
      fb       = 3'($urandom);
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic do_reset();
      clearing = 1'b1;
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1);
      check("rst_valid", out_valid, 0);
      check("rst_data", int'(out_data), 0);
      check("rst_overrun", overrun, 0);
      check("rst_we_n", sram_we_n, 0);
      check("rst_addr", int'(sram_addr), 0);
      check("rst_wdata", int'(sram_wdata), 0);
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_buf[i] = 0;
      ref_wp = 0;
   endtask

   task automatic wait_clear(input int start);
      int n = 0;
      int errs = 0;
      int nz = 0;
      while (busy && n < 4 * DEPTH) begin
         if (int'(sram_addr) != start + n || sram_we_n !== 1'b0 || sram_wdata !== '0) errs++;
         n++;
         @(negedge clk);
      end
      check("clear_cycles", n, DEPTH - start);
      check("clear_pattern_errs", errs, 0);
      check("idle_busy", busy, 0);
      check("idle_we_n", sram_we_n, 1);
      check("idle_addr", int'(sram_addr), 0);
      check("idle_wdata", int'(sram_wdata), 0);
      check("idle_valid", out_valid, 0);
      for (int i = 0; i < DEPTH; i++) if (mem[i] != 0) nz++;
      check("clear_mem_nonzero", nz, 0);
      clearing = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'sh5A5A;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; enable = 1'b0;
      level = 3'd0; mix = 2'd0; fb = 3'd0;
      @(negedge clk);

      // reset and clear
      do_reset();
      wait_clear(0);
      check("overrun_after_clear", overrun, 0);

      // impulse, no feedback, minimum sample period
      send(8000, 1'b1, 0, 2, 0, 4);
      for (int i = 0; i < 7; i++) send(0, 1'b1, 0, 2, 0, 4);

      // feedback decay
      send(8000, 1'b1, 0, 3, 4, 4);
      for (int i = 0; i < 12; i++) send(0, 1'b1, 0, 3, 4, 4);

      // saturation of the feedback write, both rails
      send(32767, 1'b1, 0, 0, 0, 4);
      for (int i = 0; i < 3; i++) send(0, 1'b1, 0, 0, 0, 4);
      send(32767, 1'b1, 0, 3, 7, 4);
      send(-32768, 1'b1, 0, 0, 0, 4);
      for (int i = 0; i < 3; i++) send(0, 1'b1, 0, 0, 0, 4);
      send(-32768, 1'b1, 0, 3, 7, 4);

      // randomized samples, all levels including the DEPTH-1 clamp
      for (int i = 0; i < 40; i++) begin
         int x;
         x = int'($urandom_range(0, 65535)) - 32768;
         if (i % 9 == 0) x = 32767;
         if (i % 9 == 4) x = -32768;
         send(x, 1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 7)), int'($urandom_range(4, 7)));
      end

      // overrun: second strobe one cycle after acceptance is dropped
      check("overrun_before", overrun, 0);
      send(1111, 1'b1, 2, 1, 3, 1);
      in_valid = 1'b1; in_data = 16'sd1234;
      @(negedge clk);
      in_valid = 1'b0;
      check("overrun_set", overrun, 1);
      repeat (2) @(negedge clk);
      send(2222, 1'b1, 1, 2, 5, 4);
      send(-3333, 1'b0, 3, 3, 1, 5);
      check("overrun_sticky", overrun, 1);

      // bypass ramp with pointer wrap from a fresh clear
      do_reset();
      wait_clear(0);
      for (int i = 1; i <= 40; i++) send(i, 1'b0, int'($urandom_range(0, 7)), 3, 7, 4);
      repeat (4) @(negedge clk);
      check("mem0_after_wrap", int'(mem[0]), 33);
      check("mem7_after_wrap", int'(mem[7]), 40);
      check("mem8_after_wrap", int'(mem[8]), 9);

      // reset while a sample is in READ: it is abandoned
      send(5000, 1'b1, 0, 2, 2, 1);
      void'(exp_q.pop_back());
      void'(wr_q.pop_back());
      do_reset();
      in_valid = 1'b1; in_data = 16'sd77;
      @(negedge clk);
      in_valid = 1'b0;
      check("overrun_in_clear", overrun, 1);
      wait_clear(1);
      send(4000, 1'b1, 0, 1, 0, 4);
      send(-4000, 1'b1, 7, 3, 7, 4);

      repeat (20) @(negedge clk);
      check("pending_out", exp_q.size(), 0);
      check("pending_wr", wr_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
